// File: rtl/cmul_scheduler_if.sv
// rtl/cmul_scheduler_if.sv - operand, result and multiplier bus of cmul_scheduler (conj_b exists only with CMUL_CONJ_EN)
interface cmul_scheduler_if #(parameter int DATA_WIDTH = 16);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] ar;
  logic [DATA_WIDTH-1:0] ai;
  logic [DATA_WIDTH-1:0] br;
  logic [DATA_WIDTH-1:0] bi;
`ifdef CMUL_CONJ_EN
  logic                  conj_b;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] re;
  logic [DATA_WIDTH-1:0] im;
  logic                  err;
  logic                  mul_enable;
  logic [DATA_WIDTH-1:0] mul_a;
  logic [DATA_WIDTH-1:0] mul_b;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;

  modport slave (
`ifdef CMUL_CONJ_EN
    input  conj_b,
`endif
    input  in_valid, ar, ai, br, bi, out_ready, mul_done, mul_product,
    output in_ready, out_valid, re, im, err, mul_enable, mul_a, mul_b
  );

  modport master (
`ifdef CMUL_CONJ_EN
    output conj_b,
`endif
    output in_valid, ar, ai, br, bi, out_ready, mul_done, mul_product,
    input  in_ready, out_valid, re, im, err, mul_enable, mul_a, mul_b
  );
endinterface

// File: rtl/cmul_scheduler.sv
// rtl/cmul_scheduler.sv - complex multiply sequenced over one shared real multiplier
// Optional CMUL_CONJ_EN: conj_b input selects A*conj(B).
module cmul_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  cmul_scheduler_if.slave   bus
);
  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMBINE, OUT} state_t;

  state_t          state;
  logic [1:0]      k;
  logic [31:0]     wd_cnt;
  logic [DW-1:0]   op_ar, op_ai, op_br, op_bi;
  logic [DW-1:0]   p [4];
  logic [DW-1:0]   bi_eff;
  logic            in_ready, out_valid, err, mul_enable;
  logic [DW-1:0]   re, im, mul_a, mul_b;

  function automatic logic [DW-1:0] sat_addsub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic sub);
    logic [DW:0] s;
    s = sub ? ({a[DW-1], a} - {b[DW-1], b}) : ({a[DW-1], a} + {b[DW-1], b});
    return (s[DW] != s[DW-1]) ? (s[DW] ? MIN_V : MAX_V) : s[DW-1:0];
  endfunction

  // k order: ar*br, ai*bi, ar*bi, ai*br
  function automatic logic [2*DW-1:0] pick(input logic [1:0] idx,
                                           input logic [DW-1:0] xr, input logic [DW-1:0] xi,
                                           input logic [DW-1:0] yr, input logic [DW-1:0] yi);
    case (idx)
      2'd0:    return {xr, yr};
      2'd1:    return {xi, yi};
      2'd2:    return {xr, yi};
      default: return {xi, yr};
    endcase
  endfunction

`ifdef CMUL_CONJ_EN
  // The most negative value has no positive twin, so negation saturates.
  assign bi_eff = bus.conj_b ? ((bus.bi == MIN_V) ? MAX_V : ((~bus.bi) + {{(DW-1){1'b0}}, 1'b1}))
                             : bus.bi;
`else
  assign bi_eff = bus.bi;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= 2'd0;
      wd_cnt     <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      mul_enable <= 1'b0;
      err        <= 1'b0;
      re         <= '0;
      im         <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      mul_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_ar      <= bus.ar;
            op_ai      <= bus.ai;
            op_br      <= bus.br;
            op_bi      <= bi_eff;
            mul_a      <= bus.ar;
            mul_b      <= bus.br;
            k          <= 2'd0;
            in_ready   <= 1'b0;
            mul_enable <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (bus.mul_done) begin
            p[k] <= bus.mul_product;
            if (k != 2'd3) begin
              k              <= k + 2'd1;
              {mul_a, mul_b} <= pick(k + 2'd1, op_ar, op_ai, op_br, op_bi);
              mul_enable     <= 1'b1;
              state          <= ISSUE;
            end else begin
              state <= COMBINE;
            end
          end else if (TIMEOUT != 0 && wd_cnt == 32'(TIMEOUT - 1)) begin
            // Stalled multiplier: abandon the remaining products and flag the result.
            re        <= '0;
            im        <= '0;
            err       <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        COMBINE: begin
          re        <= sat_addsub(p[0], p[1], 1'b1);
          im        <= sat_addsub(p[2], p[3], 1'b0);
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.re         = re;
  assign bus.im         = im;
  assign bus.err        = err;
  assign bus.mul_enable = mul_enable;
  assign bus.mul_a      = mul_a;
  assign bus.mul_b      = mul_b;
endmodule

// File: tb/tb_cmul_scheduler.sv
// tb/tb_cmul_scheduler.sv - scoreboard bench for cmul_scheduler with a behavioural Q10.5 multiplier
module tb_cmul_scheduler;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cmul_scheduler_if #(.DATA_WIDTH(DW)) bus ();
  cmul_scheduler #(.DATA_WIDTH(DW), .TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int re;
    int im;
    int err;
    int lat;
    int en;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int lat_l = 1;
  bit dead = 1'b0;
  bit mock = 1'b0;
  int mock_q[$];
  int mcnt = 0;
  logic [DW-1:0] pend = '0;
  logic model_done = 1'b0;
  logic stray = 1'b0;
  logic [DW-1:0] model_prod = '0;
`ifdef CMUL_CONJ_EN
  bit conj_sel = 1'b0;
`endif

  assign bus.mul_done    = model_done | stray;
  assign bus.mul_product = model_prod;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mulsat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint pr;
    pr = (longint'($signed(a)) * longint'($signed(b))) >>> 5;
    if (pr > 32767) return 32767;
    if (pr < -32768) return -32768;
    return int'(pr);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) mcnt = 0;
  end

  // Behavioural multiplier: done arrives lat_l cycles after the enable cycle.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0 && !dead) begin
        model_done = 1'b1;
        model_prod = pend;
      end
    end
    if (bus.mul_enable === 1'b1 && !reset) begin
      chk("enable_while_outstanding", mcnt, 0);
      mcnt = lat_l;
      if (mock && mock_q.size() != 0) pend = DW'(mock_q.pop_front());
      else pend = DW'(mulsat(bus.mul_a, bus.mul_b));
    end
  end

  // Monitor: latency, enable count, stability under backpressure, result compare.
  bit prev_valid = 1'b0;
  bit prev_ready = 1'b1;
  int acc_cyc = 0;
  int en_seen = 0;
  logic [DW-1:0] hold_re, hold_im;
  logic hold_err;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b1;
    end else begin
      if (prev_ready && bus.in_ready === 1'b0) begin
        acc_cyc = cyc;
        en_seen = 0;
      end
      if (bus.mul_enable === 1'b1) en_seen++;
      if (bus.out_valid === 1'b1) begin
        chk("in_ready_low_while_out_valid", int'(bus.in_ready), 0);
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got re=%0d im=%0d expected no output",
                     $signed(bus.re), $signed(bus.im));
          end else if (sb[0].lat >= 0) begin
            chk("out_valid_latency", cyc - acc_cyc, sb[0].lat);
          end
          hold_re  = bus.re;
          hold_im  = bus.im;
          hold_err = bus.err;
        end else begin
          chk("re_stable", int'($signed(bus.re)), int'($signed(hold_re)));
          chk("im_stable", int'($signed(bus.im)), int'($signed(hold_im)));
          chk("err_stable", int'(bus.err), int'(hold_err));
        end
        if (bus.out_ready === 1'b1 && sb.size() != 0) begin
          e = sb.pop_front();
          chk("re", int'($signed(bus.re)), e.re);
          chk("im", int'($signed(bus.im)), e.im);
          chk("err", int'(bus.err), e.err);
          chk("mul_enable_count", en_seen, e.en);
        end
      end
      prev_valid = (bus.out_valid === 1'b1);
      prev_ready = (bus.in_ready === 1'b1);
    end
  end

  task automatic send(input int a_r, input int a_i, input int b_r, input int b_i, input bit push,
                      input int ere, input int eim, input int eerr, input int elat, input int een);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("in_ready_wait_expired", 0, 1);
    bus.ar = DW'(a_r);
    bus.ai = DW'(a_i);
    bus.br = DW'(b_r);
    bus.bi = DW'(b_i);
`ifdef CMUL_CONJ_EN
    bus.conj_b = conj_sel;
`endif
    if (push) sb.push_back('{ere, eim, eerr, elat, een});
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid === 1'b1) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("drain_expired", 0, 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_mul_enable", int'(bus.mul_enable), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_re", int'($signed(bus.re)), 0);
    chk("rst_im", int'($signed(bus.im)), 0);
    chk("rst_mul_a", int'($signed(bus.mul_a)), 0);
    chk("rst_mul_b", int'($signed(bus.mul_b)), 0);
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.ar        = '0;
    bus.ai        = '0;
    bus.br        = '0;
    bus.bi        = '0;
    bus.out_ready = 1'b1;
`ifdef CMUL_CONJ_EN
    bus.conj_b    = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) tick();
    check_reset_vals();
    reset = 1'b0;
    tick();

    // (2.5 - 1j)(4 + 0.5j) = 10.5 - 2.75j
    lat_l = 1;
    send(80, -32, 128, 16, 1'b1, 336, -88, 0, 9, 4);
    drain();

    // (-2 + 1.5j)(1 - 3j) = 2.5 + 7.5j
    lat_l = 2;
    send(-64, 48, 32, -96, 1'b1, 80, 240, 0, 13, 4);
    drain();

    lat_l = 3;
    bus.out_ready = 1'b0;
    send(80, -32, 128, 16, 1'b1, 336, -88, 0, 17, 4);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("out_valid_wait_expired", 0, 1);
    repeat (5) tick();
    chk("bp_out_valid_held", int'(bus.out_valid), 1);
    chk("bp_in_ready_low", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    drain();

    lat_l = 1;
    mock = 1'b1;
    mock_q = '{32767, -100, -32768, -1};
    send(0, 0, 0, 0, 1'b1, 32767, -32768, 0, 9, 4);
    drain();
    mock = 1'b0;

    dead = 1'b1;
    send(80, -32, 128, 16, 1'b1, 0, 0, 1, -1, 1);
    drain();
    dead = 1'b0;
    send(80, -32, 128, 16, 1'b1, 336, -88, 0, 9, 4);
    drain();

    // Abort in the second WAIT, then a stray done that must be ignored.
    lat_l = 3;
    send(80, -32, 128, 16, 1'b0, 0, 0, 0, -1, 0);
    n = 0;
    while (!(en_seen == 2 && bus.mul_enable === 1'b0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("second_wait_expired", 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stray = 1'b1;
    check_reset_vals();
    tick();
    stray = 1'b0;
    chk("post_stray_in_ready", int'(bus.in_ready), 1);
    chk("post_stray_mul_enable", int'(bus.mul_enable), 0);
    chk("post_stray_out_valid", int'(bus.out_valid), 0);
    tick();
    chk("post_stray_idle_enable", int'(bus.mul_enable), 0);
    lat_l = 1;
    send(80, -32, 128, 16, 1'b1, 336, -88, 0, 9, 4);
    drain();

`ifdef CMUL_CONJ_EN
    // (2.5 - 1j)(4 - 0.5j) = 9.5 - 5.25j
    conj_sel = 1'b1;
    send(80, -32, 128, 16, 1'b1, 304, -168, 0, 9, 4);
    drain();
    conj_sel = 1'b0;
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmul_scheduler.md
# cmul_scheduler

Sequences one shared `fixed_point_multiplier` to compute a complex product (ar + j·ai)·(br + j·bi) for the FFT butterfly path. It issues four real multiplies one at a time, waits for the multiplier's `done` each time, and then combines the results with saturating add/sub. Operands and result use the same signed Qm.n format as the multiplier. The scheduler does no shifting, so it is format-agnostic.

## Interface
- `DATA_WIDTH`, 16: width of every operand, product and result (signed two's complement).
- `TIMEOUT`, 64: maximum cycles to wait for `mul_done` per product; 0 disables the watchdog.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand set valid.
- `in_ready`  out  1  scheduler can accept operands.
- `ar`, `ai`, `br`, `bi`  in  DATA_WIDTH each  complex operands A and B.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts result.
- `re`, `im`  out  DATA_WIDTH each  saturated result.
- `err`  out  1  qualifies `out_valid`: multiplier timed out, result forced to 0.
- `mul_enable`  out  1  one-cycle start pulse to the multiplier.
- `mul_a`, `mul_b`  out  DATA_WIDTH each  multiplier operands.
- `mul_done`  in  1  multiplier result valid.
- `mul_product`  in  DATA_WIDTH  multiplier result, already saturated by the multiplier.

## Operation
- States: IDLE, ISSUE, WAIT, COMBINE, OUT. A 2-bit index `k` selects the product.
  - k=0: ar·br
  - k=1: ai·bi
  - k=2: ar·bi
  - k=3: ai·br
- IDLE: `in_ready`=1. If `in_valid`, register all four operands, set k=0, go to ISSUE.
- ISSUE: `mul_enable`=1 for exactly this cycle, with `mul_a`/`mul_b` driven by the pair for k. Go to WAIT.
- WAIT: `mul_a`/`mul_b` are held stable.
  - If `mul_done`, capture `mul_product` into p[k].
  - If k<3, increment k and go to ISSUE; else go to COMBINE.
- `mul_done` is ignored in every state except WAIT.
- COMBINE:
  - re = sat(p0 − p1), im = sat(p2 + p3).
  - Both are computed at DATA_WIDTH+1 bits, then clamped to [−2^(DW−1), 2^(DW−1)−1].
  - Go to OUT.
- OUT: `out_valid`=1, with `re`/`im`/`err` stable. On `out_ready`, go to IDLE.
- Watchdog:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without `mul_done`: `re`=`im`=0, `err`=1, go directly to OUT. Remaining products are skipped.
  - `err` clears on the next acceptance.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `mul_enable`=0, `err`=0; `re`, `im`, `mul_a`, `mul_b` = 0; k=0.
- Reset has priority in every state. A reset during WAIT aborts the transaction; a `mul_done` arriving later is ignored.

## Timing
- Multiplier latency L: `mul_done` is asserted L≥1 cycles after the `mul_enable` cycle.
- With acceptance at edge t0:
  - `mul_enable` pulses at cycles t0, t0+(L+1), t0+2(L+1), t0+3(L+1).
  - `out_valid` first asserts at cycle t0+4(L+1)+1.
  - For L=1, `out_valid` is at cycle 9 after acceptance.
- `in_ready` reasserts the cycle after the OUT handshake. There is no overlap between transactions.
- `in_ready` and `out_valid` are never both 1.
- `mul_enable` is never asserted while a product is outstanding.

## Configuration
- `CMUL_CONJ_EN` defined:
  - Adds input port `conj_b` (1 bit), sampled with the operands.
  - When `conj_b`=1, `bi` is replaced by its saturated negation before scheduling. −2^(DW−1) maps to 2^(DW−1)−1.
  - This yields A·conj(B) for the inverse FFT.
- `CMUL_CONJ_EN` undefined: the port is absent and `bi` is used unmodified.

## Test plan
All values are Q10.5 (raw = value·32). Bench uses a behavioural multiplier with configurable L unless noted.
- **Basic product:** L=1; A=(80,−32), B=(128,16) → `re`=336 (10.5), `im`=−88 (−2.75); `out_valid` at cycle 9; exactly 4 `mul_enable` pulses.
- **Latency and backpressure:** L=3; same operands → `out_valid` at cycle 17. Hold `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0 throughout.
- **Saturation:** mock products p0=32767, p1=−100, p2=−32768, p3=−1 → `re`=32767, `im`=−32768, `err`=0.
- **Timeout:** TIMEOUT=8, `mul_done` never asserted → `out_valid` with `err`=1 and `re`=`im`=0. Next transaction with a working multiplier → `err`=0 and correct result.
- **Reset mid-operation:** reset in the second WAIT, then a stray `mul_done` → all outputs at reset values and `in_ready`=1 the cycle after reset. A fresh transaction gives the correct result.
- **Conjugate (with `CMUL_CONJ_EN`):** `conj_b`=1, A=(80,−32), B=(128,16) → `re`=304 (9.5), `im`=−168 (−5.25).
